// File: rtl/seq_protocol_checker.sv
// Monitor for the sequence property "C, BMIN..BMAX x B, A |=> JLEN x J, K" with X as abort.
// Tracks overlapping attempts and reports registered pulses and saturating event counters.
module seq_protocol_checker #(
  parameter int unsigned BMIN  = 1,
  parameter int unsigned BMAX  = 3,
  parameter int unsigned JLEN  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             J,
  input  logic             K,
  input  logic             X,
  output logic             pass,
  output logic             fail,
  output logic             disabled,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] dis_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // bmask bit k-1 holds "C followed by exactly k B samples"; only BMIN..BMAX may accept A
  localparam logic [BMAX-1:0]  WIN     = {BMAX{1'b1}} << (BMIN - 1);

  logic            c_q, c_d;
  logic [BMAX-1:0] bmask_q, bmask_d, bmask_nx;
  logic [JLEN:0]   oblig_q, oblig_d, oblig_nx;
  logic            match;
  logic            pass_d, fail_d, dis_d;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic ev, input logic clr);
    if (clr) return '0;
    if (ev && (cur != CNT_MAX)) return cur + CNT_W'(1);
    return cur;
  endfunction

  assign match       = A & (|(bmask_q & WIN));
  assign bmask_nx[0] = B & c_q;
  assign oblig_nx[0] = match;

  for (genvar k = 1; k < BMAX; k++) begin : g_bmask
    assign bmask_nx[k] = B & bmask_q[k-1];
  end

  for (genvar i = 0; i < JLEN; i++) begin : g_oblig
    assign oblig_nx[i+1] = oblig_q[i] & J;
  end

  assign busy = c_q | (|bmask_q) | (|oblig_q);

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_q     <= 1'b0;
      bmask_q <= '0;
      oblig_q <= '0;
    end else begin
      c_q     <= c_d;
      bmask_q <= bmask_d;
      oblig_q <= oblig_d;
    end
  end

  // next state and pulse evaluation; X wipes every attempt
  always_comb begin
    c_d     = 1'b0;
    bmask_d = '0;
    oblig_d = '0;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    dis_d   = 1'b0;
    if (X) begin
      dis_d = busy;
    end else begin
      c_d     = C;
      bmask_d = bmask_nx;
      oblig_d = oblig_nx;
      pass_d  = oblig_q[JLEN] & K;
      fail_d  = ((|oblig_q[JLEN-1:0]) & ~J) | (oblig_q[JLEN] & ~K);
    end
  end

  // registered pulses and counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pass     <= 1'b0;
      fail     <= 1'b0;
      disabled <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      dis_cnt  <= '0;
    end else begin
      pass     <= pass_d;
      fail     <= fail_d;
      disabled <= dis_d;
      pass_cnt <= cnt_next(pass_cnt, pass_d, CLR);
      fail_cnt <= cnt_next(fail_cnt, fail_d, CLR);
      dis_cnt  <= cnt_next(dis_cnt, dis_d, CLR);
    end
  end

endmodule
